// File: rtl/fp_multiplier.sv
// Sequential IEEE-754-style multiplier: shift-add mantissa product, one bit per clock.
// Latency: done_out pulses MANTISSA_WIDTH+3 rising edges after the accepting edge, independent of data.
// Backpressure: none; start_in is ignored while busy_out=1. Build option FPM_ROUND_EN selects round-to-nearest-even (default truncates).
module fp_multiplier #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]     a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]     b_in,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]     result_out,
  output logic                                  done_out,
  output logic                                  busy_out,
  output logic                                  overflow_out,
  output logic                                  underflow_out
);

  localparam int W  = 1 + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int M  = MANTISSA_WIDTH;
  localparam int E  = EXP_WIDTH;
  localparam int PW = 2 * M + 2;
  localparam int CW = $clog2(M + 2);
  localparam int XW = E + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_PACK = 2'd3;

  localparam logic [CW-1:0]        LAST_CNT = CW'(M);
  localparam logic [E-1:0]         BIAS     = {1'b0, {(E-1){1'b1}}};
  localparam logic signed [XW-1:0] EXP_MAX  = $signed({2'b00, {E{1'b1}}});
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic [M-1:0]         NAN_FRAC = {1'b1, {(M-1){1'b0}}};

  // Registered state
  logic [1:0]              state_q,  state_d;
  logic [W-1:0]            a_q,      a_d;
  logic [W-1:0]            b_q,      b_d;
  logic [PW-1:0]           mcand_q,  mcand_d;
  logic [M:0]              mplier_q, mplier_d;
  logic [PW-1:0]           prod_q,   prod_d;
  logic [CW-1:0]           cnt_q,    cnt_d;
  logic signed [XW-1:0]    exp_q,    exp_d;
  logic                    sticky_q, sticky_d;
  logic [W-1:0]            result_q, result_d;
  logic                    done_q,   done_d;
  logic                    busy_q,   busy_d;
  logic                    ovf_q,    ovf_d;
  logic                    unf_q,    unf_d;

  // Operand unpack (from the input ports, used only on the accepting edge)
  logic [E-1:0]            a_exp_in, b_exp_in;
  logic [M:0]              a_man_in, b_man_in;
  logic signed [XW-1:0]    exp_sum_in;

  // Operand classification (from the latched operands, stable for the whole operation)
  logic [E-1:0]            a_exp, b_exp;
  logic [M-1:0]            a_frac, b_frac;
  logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                    res_sign;

  // Rounding / final packing
  logic [M-1:0]            frac_t;
  logic                    guard_bit, sticky_bit, round_inc;
  logic [M+1:0]            man_r;
  logic [M-1:0]            frac_r;
  logic signed [XW-1:0]    exp_r;

  // Unpack incoming operands; the hidden bit is set only for non-zero exponents
  always_comb begin
    a_exp_in   = a_in[W-2:M];
    b_exp_in   = b_in[W-2:M];
    a_man_in   = {(|a_exp_in), a_in[M-1:0]};
    b_man_in   = {(|b_exp_in), b_in[M-1:0]};
    exp_sum_in = $signed({2'b00, a_exp_in}) + $signed({2'b00, b_exp_in})
               - $signed({2'b00, BIAS});
  end

  // Classify latched operands for the special-value paths
  always_comb begin
    a_exp    = a_q[W-2:M];
    b_exp    = b_q[W-2:M];
    a_frac   = a_q[M-1:0];
    b_frac   = b_q[M-1:0];
    a_zero   = (a_exp == '0);
    b_zero   = (b_exp == '0);
    a_inf    = (&a_exp) && (a_frac == '0);
    b_inf    = (&b_exp) && (b_frac == '0);
    a_nan    = (&a_exp) && (a_frac != '0);
    b_nan    = (&b_exp) && (b_frac != '0);
    res_sign = a_q[W-1] ^ b_q[W-1];
  end

  // Extract fraction/guard/sticky from the normalised product and apply rounding
  always_comb begin
    // After NORM the hidden bit sits at PW-2; fraction is the next M bits down.
    frac_t     = prod_q[PW-3 -: M];
    guard_bit  = prod_q[M-1];
    sticky_bit = (|prod_q[M-2:0]) | sticky_q;
`ifdef FPM_ROUND_EN
    round_inc  = guard_bit & (sticky_bit | frac_t[0]);
`else
    // Truncation: bits below the fraction are deliberately discarded.
    round_inc  = 1'b0 & guard_bit & sticky_bit;
`endif
    man_r = {1'b0, 1'b1, frac_t} + (M+2)'(round_inc);
    if (man_r[M+1]) begin
      // Rounding carried out of the mantissa: renormalise before range checks.
      frac_r = man_r[M:1];
      exp_r  = exp_q + EXP_ONE;
    end else begin
      frac_r = man_r[M-1:0];
      exp_r  = exp_q;
    end
  end

  // Next-state and datapath control for IDLE/MULT/NORM/PACK
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    sticky_d = sticky_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          a_d      = a_in;
          b_d      = b_in;
          mcand_d  = {{(M+1){1'b0}}, a_man_in};
          mplier_d = b_man_in;
          prod_d   = '0;
          cnt_d    = '0;
          exp_d    = exp_sum_in;
          sticky_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_MULT;
        end
      end

      S_MULT: begin
        // One multiplier bit per clock, LSB first; multiplicand walks left.
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        // Product of two [1,2) mantissas lies in [1,4); fold the top binade down.
        if (prod_q[PW-1]) begin
          prod_d   = prod_q >> 1;
          sticky_d = prod_q[0];
          exp_d    = exp_q + EXP_ONE;
        end
        state_d = S_PACK;
      end

      default: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          result_d = {1'b0, {E{1'b1}}, NAN_FRAC};
        end else if (a_inf || b_inf) begin
          result_d = {res_sign, {E{1'b1}}, {M{1'b0}}};
        end else if (a_zero || b_zero) begin
          result_d = {res_sign, {(W-1){1'b0}}};
        end else if (exp_r >= EXP_MAX) begin
          result_d = {res_sign, {E{1'b1}}, {M{1'b0}}};
          ovf_d    = 1'b1;
        end else if (exp_r <= $signed({XW{1'b0}})) begin
          result_d = {res_sign, {(W-1){1'b0}}};
          unf_d    = 1'b1;
        end else begin
          result_d = {res_sign, exp_r[E-1:0], frac_r};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset (aborts any operation)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      sticky_q <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign result_out    = result_q;
  assign done_out      = done_q;
  assign busy_out      = busy_q;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;

endmodule

// File: tb/tb_fp_multiplier.sv
// Directed bench for fp_multiplier (single precision defaults); scoreboard of expected results.
// Latency and busy checks each operation; build with FPM_ROUND_EN to check the rounding path.
module tb_fp_multiplier;

  localparam int LAT     = 23 + 3;
  localparam int TIMEOUT = 60;

  logic        clk;
  logic        rst_n;
  logic        start_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] result_out;
  logic        done_out;
  logic        busy_out;
  logic        overflow_out;
  logic        underflow_out;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {result, overflow, underflow}
  logic [33:0] sb_q[$];

  fp_multiplier #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_in      (start_in),
    .a_in          (a_in),
    .b_in          (b_in),
    .result_out    (result_out),
    .done_out      (done_out),
    .busy_out      (busy_out),
    .overflow_out  (overflow_out),
    .underflow_out (underflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, optionally re-pulse start_in mid-flight, and check the result.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_ovf, input logic exp_unf,
                        input int glitch_at);
    logic [33:0] ent;
    logic [31:0] held;
    int cyc;
    bit busy_bad;
    sb_q.push_back({exp_res, exp_ovf, exp_unf});
    @(negedge clk);
    a_in = a; b_in = b; start_in = 1'b1;
    @(negedge clk);             // accepting edge has passed
    start_in = 1'b0;
    cyc = 0;
    busy_bad = (busy_out !== 1'b1);
    while (done_out !== 1'b1 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      if (cyc == glitch_at) begin
        a_in = 32'h3F800000; b_in = 32'h3F800000; start_in = 1'b1;
      end else begin
        start_in = 1'b0;
      end
      if (done_out !== 1'b1 && busy_out !== 1'b1) busy_bad = 1'b1;
    end
    start_in = 1'b0;
    check({tag, " done seen"},    64'(done_out), 64'd1);
    check({tag, " latency"},      64'(cyc), 64'(LAT));
    check({tag, " busy held"},    64'(busy_bad), 64'd0);
    check({tag, " busy cleared"}, 64'(busy_out), 64'd0);
    ent = (sb_q.size() > 0) ? sb_q.pop_front() : 34'h0;
    check({tag, " result"},    64'(result_out),    64'(ent[33:2]));
    check({tag, " overflow"},  64'(overflow_out),  64'(ent[1]));
    check({tag, " underflow"}, 64'(underflow_out), 64'(ent[0]));
    held = result_out;
    @(negedge clk);
    check({tag, " done pulse width"}, 64'(done_out), 64'd0);
    check({tag, " result held"},      64'(result_out), 64'(held));
  endtask

  // Start an operation and assert reset 10 cycles in; no completion may appear.
  task automatic abort_op(input logic [31:0] a, input logic [31:0] b);
    bit saw_done;
    @(negedge clk);
    a_in = a; b_in = b; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_out === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    check("abort outputs cleared",
          64'({result_out, done_out, busy_out, overflow_out, underflow_out}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_out === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 5; i++) begin
      @(negedge clk);
      if (done_out === 1'b1) saw_done = 1'b1;
    end
    check("abort no done", 64'(saw_done), 64'd0);
    check("abort idle",    64'({busy_out, result_out}), 64'd0);
  endtask

  logic [31:0] rnd_exp;

  initial begin
    rst_n    = 1'b0;
    start_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    #12;
    check("reset outputs",
          64'({result_out, done_out, busy_out, overflow_out, underflow_out}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef FPM_ROUND_EN
    rnd_exp = 32'h40100002;
`else
    rnd_exp = 32'h40100001;
`endif

    run_op("2x3",          32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 0);
    run_op("overflow",     32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 0);
    run_op("max finite",   32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0, 0);
    run_op("underflow",    32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1, 0);
    run_op("neg x zero",   32'hBFC00000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 0);
    run_op("inf x zero",   32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 0);
    run_op("subnormal in", 32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 0);
    run_op("rounding",     32'h3FC00001, 32'h3FC00001, rnd_exp,      1'b0, 1'b0, 0);
    run_op("neg product",  32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, 0);
    run_op("nan operand",  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 0);
    run_op("inf x neg",    32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 1'b0, 0);
    run_op("one x one",    32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 0);
    run_op("start ignored",32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 5);

    abort_op(32'h40000000, 32'h40400000);
    run_op("after reset",  32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, 0);

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_multiplier.md
FP_MULTIPLIER -- requirements
Module: fp_multiplier

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, stored fraction width; word width W = 1+EXP_WIDTH+MANTISSA_WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_in  input  1  operand-valid strobe.
REQ-006 SHALL have port a_in  input  W  multiplicand, IEEE-754 layout {sign, exp, frac}.
REQ-007 SHALL have port b_in  input  W  multiplier, same layout.
REQ-008 SHALL have port result_out  output  W  product.
REQ-009 SHALL have port done_out  output  1  one-cycle completion pulse.
REQ-010 SHALL have port busy_out  output  1  high while an operation is in flight.
REQ-011 SHALL have port overflow_out  output  1  result saturated to infinity.
REQ-012 SHALL have port underflow_out  output  1  result flushed to zero.

Function
REQ-013 SHALL use FSM states IDLE, MULT, NORM, PACK; IDLE->MULT on start_in, MULT->NORM after MANTISSA_WIDTH+1 iterations, NORM->PACK, PACK->IDLE unconditionally.
REQ-014 SHALL, in IDLE with start_in=1, latch a_in/b_in, unpack with hidden bit, and set busy_out=1 on that edge.
REQ-015 SHALL ignore start_in while busy_out=1; latched operands SHALL NOT change mid-operation.
REQ-016 SHALL compute the (2*MANTISSA_WIDTH+2)-bit mantissa product by shift-add, one multiplier bit per clock in MULT.
REQ-017 SHALL compute the biased exponent as ea+eb-bias in a signed EXP_WIDTH+2-bit field; bias = 2^(EXP_WIDTH-1)-1.
REQ-018 SHALL, in NORM, shift the product right by one and increment the exponent when its MSB is set.
REQ-019 SHALL, in PACK, register result_out, overflow_out, underflow_out, assert done_out for exactly one cycle, and clear busy_out.
REQ-020 SHALL have fixed latency: done_out high in the cycle after the 26th rising edge following the start edge (MANTISSA_WIDTH+3 edges in general), independent of operand values.
REQ-021 SHALL hold result_out and flags stable from done_out until the next PACK.
REQ-022 SHALL set result sign = sign_a XOR sign_b for all non-NaN results.
REQ-023 SHALL treat operands with exponent 0 as signed zero (subnormals flushed on input).
REQ-024 SHALL produce canonical NaN {0, all-ones exp, 1 followed by zeros} for any NaN operand or Inf*0; flags 0.
REQ-025 SHALL produce signed Inf for Inf*finite-nonzero, flags 0.
REQ-026 SHALL produce signed Inf with overflow_out=1 when the final biased exponent >= 2^EXP_WIDTH-1.
REQ-027 SHALL produce signed zero with underflow_out=1 when the final biased exponent <= 0 and both operands are nonzero.
REQ-028 SHALL produce signed zero with flags 0 when either operand is zero (no NaN/Inf).

Reset
REQ-029 SHALL, on rst_n low, immediately force state IDLE, result_out=0, done_out=0, busy_out=0, overflow_out=0, underflow_out=0, and clear the internal accumulator/counter.
REQ-030 SHALL abort an in-flight operation on reset with no done_out pulse; the first start_in after rst_n rises SHALL be accepted normally.

Configuration
REQ-031 SHALL, with FPM_ROUND_EN defined, round to nearest even using guard and sticky bits in PACK, re-normalising on rounding carry-out before the overflow check of REQ-026.
REQ-032 SHALL, without FPM_ROUND_EN, truncate the fraction (round toward zero); latency is identical in both builds.

Verification
REQ-033 SHALL cover 0x40000000 * 0x40400000 -> result 0x40C00000, flags 0, done_out exactly MANTISSA_WIDTH+3 edges after start, busy_out high throughout.
REQ-034 SHALL cover 0x7F000000 * 0x40000000 -> 0x7F800000, overflow_out=1; and 0x00800000 * 0x3F000000 -> 0x00000000, underflow_out=1.
REQ-035 SHALL cover 0xBFC00000 * 0x00000000 -> 0x80000000 flags 0; 0x7F800000 * 0x00000000 -> 0x7FC00000.
REQ-036 SHALL cover 0x3FC00001 * 0x3FC00001 -> 0x40100002 with FPM_ROUND_EN, 0x40100001 without.
REQ-037 SHALL cover start_in pulsed again 5 cycles into an operation -> ignored, original result delivered; rst_n low 10 cycles into an operation -> all outputs 0, no done_out, next operation correct.
